eq_serial_cmp: RTL
==================

Name: eq_serial_cmp

Overview:
- Parametrised, multi-cycle magnitude/equality comparator for two W-bit unsigned words.
- Compares S bits per clock from MSB slice down to LSB slice and terminates early on the first unequal slice.
- Reports eq/gt/lt with a done tick and keeps a saturating count of equal results.
- Sits beside the combinational equality cells. Used where W is too wide for single-cycle timing, or where a result history is needed.

Parameters:
W, 16, operand width in bits; must be an integer multiple of S
S, 4, slice width compared per clock; 1 <= S <= W
CW, 8, width of the equal-result counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a comparison; sampled only when ready=1
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
ready  output  1  block is idle and will accept start
done_tick  output  1  one-cycle pulse: result outputs valid and updated
eq  output  1  a == b for the last completed comparison
gt  output  1  a > b (unsigned) for the last completed comparison
lt  output  1  a < b (unsigned) for the last completed comparison
eq_count  output  CW  number of completed comparisons with eq=1, saturating
clr_count  input  1  synchronous clear of eq_count

Behaviour:
- Constant N = W/S slices. Slice k is bits [k*S+S-1 : k*S]. Compare order is k = N-1 down to 0.
- Reset (synchronous, active-high; clk edge with reset=1):
  - state=IDLE, ready=1, done_tick=0, eq=0, gt=0, lt=0, eq_count=0.
  - Internal operand registers and slice index are cleared.
  - Reset mid-operation abandons the comparison: no done_tick, no count update.
- FSM:
  - IDLE (ready=1):
    - start=1 → latch a,b into internal registers, idx=N-1, go CMP.
    - Result outputs keep their previous values until the new result commits.
  - CMP (ready=0):
    - Compare slice idx of the latched operands; live a/b inputs are ignored.
    - Slices unequal → gt = (a_slice > b_slice), lt = ~gt, eq=0; go DONE.
    - Slices equal and idx==0 → eq=1, gt=0, lt=0; go DONE.
    - Slices equal and idx>0 → idx = idx-1; stay CMP.
  - DONE (ready=0): done_tick=1 for exactly this cycle; go IDLE.
- Latency (start accepted in cycle 0):
  - First mismatch at slice position j from the top (j=0 is the MSB slice): done_tick in cycle j+2.
  - Full equality: done_tick in cycle N+1.
  - Back-to-back throughput: next start is accepted in the cycle after done_tick.
- start while ready=0 (CMP or DONE) is ignored and is not queued.
- Results are exactly one-hot among {eq,gt,lt} after the first completion. All three are 0 only between reset and the first completion.
- eq_count:
  - Increments by 1 on the same edge eq=1 commits, i.e. becomes visible with done_tick.
  - Saturates at 2^CW-1; no wrap.
  - clr_count=1 zeroes it on the next edge.
  - clr_count coinciding with an increment → result is 0 (clear wins).
  - reset overrides clr_count.
- Degenerate S=W: N=1; every comparison completes with done_tick in cycle 2.

Test Plan:
- W=16,S=4: reset held 2 cycles → ready=1, done_tick=0, eq=gt=lt=0, eq_count=0.
- a=16'hA5C3, b=16'hA5C3, start in cycle 0 → done_tick only in cycle 5, eq=1, gt=lt=0, eq_count=1; ready=1 again in cycle 6.
- a=16'h9000, b=16'h1FFF → mismatch in MSB slice; done_tick in cycle 2, gt=1, lt=0, eq=0; eq_count unchanged.
- a=16'h12F4, b=16'h12F5 → mismatch in LSB slice; done_tick in cycle 5, lt=1. start pulses in cycles 1-4 with different a/b are ignored, and the result is unchanged.
- CW=2: four equal comparisons back-to-back → eq_count 1,2,3,3 (saturated). Then clr_count asserted coincident with a fifth equal result's commit → eq_count=0.
- reset asserted in cycle 2 of a full-length equal comparison → no done_tick, eq_count unchanged at 0, ready=1 from cycle 3. A new start in cycle 3 completes normally.

Source files
------------

// File: rtl/eq_serial_cmp_if.sv
// Request/result bundle for the serial magnitude/equality comparator.
interface eq_serial_cmp_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
);
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          clr_count;
  logic          ready;
  logic          done_tick;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [CW-1:0] eq_count;

  modport master (
    output start, a, b, clr_count,
    input  ready, done_tick, eq, gt, lt, eq_count
  );

  modport slave (
    input  start, a, b, clr_count,
    output ready, done_tick, eq, gt, lt, eq_count
  );
endinterface

// File: rtl/eq_serial_cmp.sv
// Multi-cycle W-bit unsigned comparator: walks S-bit slices from the MSB end,
// stops on the first unequal slice, and keeps a saturating count of equal results.
module eq_serial_cmp #(
  parameter int unsigned W  = 16,
  parameter int unsigned S  = 4,
  parameter int unsigned CW = 8
) (
  input  logic           clk,
  input  logic           reset,
  eq_serial_cmp_if.slave bus
);
  localparam int unsigned N  = W / S;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((S < 1) || (S > W) || ((W % S) != 0)) begin : g_bad_param
      $error("eq_serial_cmp: W must be a positive multiple of S");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [S-1:0]  a_sl_c, b_sl_c;
  logic          sl_eq_c, last_c, eq_commit_c;

  // Current slice of the latched operands
  assign a_sl_c      = a_q[32'(idx_q) * S +: S];
  assign b_sl_c      = b_q[32'(idx_q) * S +: S];
  assign sl_eq_c     = (a_sl_c == b_sl_c);
  assign last_c      = (idx_q == '0);
  assign eq_commit_c = (state_q == CMP) && sl_eq_c && last_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CMP;
      CMP:     if (!sl_eq_c || last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    cnt_d   = cnt_q;
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          idx_d = IW'(N - 1);
        end
      end
      CMP: begin
        if (!sl_eq_c) begin
          gt_d = (a_sl_c > b_sl_c);
          lt_d = (a_sl_c < b_sl_c);
          eq_d = 1'b0;
        end else if (last_c) begin
          eq_d = 1'b1;
          gt_d = 1'b0;
          lt_d = 1'b0;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: ;
    endcase

    if (eq_commit_c && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
    // Clear takes priority over a coincident increment
    if (bus.clr_count) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.eq_count  = cnt_q;
endmodule
